// File: rtl/phase_stream_pkg.sv
// Shared types and default widths for the phase stream source.
package phase_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} pss_state_t;
    localparam int DATA_WIDTH_D  = 52;
    localparam int COUNT_WIDTH_D = 16;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer with registered head; push and pop may coincide when full.
module stream_fifo2 #(
    parameter int DATA_WIDTH = 52
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic                  avail,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  do_pop;

    assign avail     = (cnt_q != 2'd0);
    assign full      = (cnt_q == 2'd2);
    assign head_data = head_q;
    assign do_pop    = pop && avail;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case (cnt_q)
            2'd0: if (push) begin
                head_d = push_data;
                cnt_d  = 2'd1;
            end
            2'd1: begin
                if (push && do_pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    cnt_d  = 2'd2;
                end else if (do_pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: if (do_pop) begin
                // tail slides into head; a same-cycle push refills the tail
                head_d = tail_q;
                if (push) tail_d = push_data;
                else      cnt_d  = 2'd1;
            end
        endcase
        if (flush) cnt_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/phase_stream_source.sv
// Burst generator of phase-accumulator words feeding an avail/get stream port.
module phase_stream_source
    import phase_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int COUNT_WIDTH = COUNT_WIDTH_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DATA_WIDTH-1:0]  start_phase,
    input  logic [DATA_WIDTH-1:0]  step,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   post_avail,
    input  logic                   post_get,
    output logic [DATA_WIDTH-1:0]  post_data
);
    pss_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d, step_q, step_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   done_q, done_d;
    logic                   push, flush, full, xfer;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign xfer = post_avail && post_get;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                acc_d  = start_phase;
                step_d = step;
                rem_d  = count;
                if (count == '0) done_d  = 1'b1;
                else             state_d = RUN;
            end
            RUN: if (!full || xfer) begin
                push  = 1'b1;
                acc_d = acc_q + step_q;
                rem_d = rem_q - 1'b1;
                if (rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
            end
            default: begin
                // no pushes happen here, so a transfer while not full empties the buffer
                if (xfer && !full) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            flush   = 1'b1;
            push    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (acc_q),
        .full      (full),
        .pop       (post_get),
        .avail     (post_avail),
        .head_data (post_data)
    );
endmodule

// File: tb/tb_phase_stream_source.sv
// Directed bench for phase_stream_source with hand-computed expected words.
module tb_phase_stream_source;
    logic        clk = 1'b0;
    logic        rst, start, abort, post_get;
    logic [51:0] start_phase, step;
    logic [15:0] count;
    logic        busy, done, post_avail;
    logic [51:0] post_data;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    phase_stream_source dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_phase(start_phase), .step(step), .count(count),
        .busy(busy), .done(done), .post_avail(post_avail),
        .post_get(post_get), .post_data(post_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start in cycle 0 and returns positioned in cycle 1.
    task automatic start_burst(input logic [51:0] sp, input logic [51:0] st, input logic [15:0] cnt);
        start_phase = sp;
        step        = st;
        count       = cnt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        start_phase = '0;
        step        = '0;
        count       = '0;
    endtask

    initial begin
        logic [51:0] exp_w;
        logic [3:0]  lfsr;
        int          k, dones, tail;

        rst = 1'b1; start = 1'b0; abort = 1'b0; post_get = 1'b0;
        start_phase = '0; step = '0; count = '0;
        tick(); tick();
        chk("reset_avail", 64'(post_avail), 64'd0);
        chk("reset_data",  64'(post_data),  64'd0);
        chk("reset_busy",  64'(busy),       64'd0);
        chk("reset_done",  64'(done),       64'd0);
        rst = 1'b0;
        tick();

        // basic burst, full throughput
        post_get = 1'b1;
        start_burst(52'h10, 52'h3, 16'd4);
        chk("t1_c1_busy",  64'(busy),       64'd1);
        chk("t1_c1_avail", 64'(post_avail), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_avail", 64'(post_avail), 64'd1);
            chk("t1_data",  64'(post_data),  64'h10 + 64'(3 * i));
            chk("t1_nodone", 64'(done),      64'd0);
        end
        tick();
        chk("t1_c6_done",  64'(done),       64'd1);
        chk("t1_c6_busy",  64'(busy),       64'd0);
        chk("t1_c6_avail", 64'(post_avail), 64'd0);
        tick();
        chk("t1_c7_done",  64'(done),       64'd0);

        // wraparound modulo 2**52
        start_burst(52'hF_FFFF_FFFF_FFFE, 52'h3, 16'd3);
        tick(); chk("t2_w0", 64'(post_data), 64'hF_FFFF_FFFF_FFFE);
        tick(); chk("t2_w1", 64'(post_data), 64'h1);
        tick(); chk("t2_w2", 64'(post_data), 64'h4);
        tick(); chk("t2_done", 64'(done), 64'd1);
        tick();

        // backpressure: held until cycle 10
        post_get = 1'b0;
        start_burst(52'h100, 52'h7, 16'd5);
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk("t3_hold_avail", 64'(post_avail), 64'd1);
            chk("t3_hold_data",  64'(post_data),  64'h100);
        end
        tick();
        post_get = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_avail", 64'(post_avail), 64'd1);
            chk("t3_data",  64'(post_data),  64'h100 + 64'(7 * i));
            chk("t3_nodone", 64'(done), 64'd0);
            tick();
        end
        chk("t3_done",  64'(done),       64'd1);
        chk("t3_empty", 64'(post_avail), 64'd0);
        tick();
        chk("t3_done_once", 64'(done), 64'd0);

        // zero-length burst
        start_burst(52'h55, 52'h1, 16'd0);
        chk("t4_done",  64'(done),       64'd1);
        chk("t4_busy",  64'(busy),       64'd0);
        chk("t4_avail", 64'(post_avail), 64'd0);
        tick();
        chk("t4_done_clr", 64'(done),       64'd0);
        chk("t4_avail2",   64'(post_avail), 64'd0);

        // abort mid-burst, then a fresh burst
        start_burst(52'h200, 52'h2, 16'd100);
        for (int c = 2; c <= 6; c++) tick();
        chk("t5_c6_data", 64'(post_data), 64'h208);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_avail", 64'(post_avail), 64'd0);
        chk("t5_busy",  64'(busy),       64'd0);
        chk("t5_done",  64'(done),       64'd0);
        tick();
        chk("t5_done2", 64'(done),       64'd0);
        start_burst(52'h900, 52'h5, 16'd2);
        tick(); chk("t5_re_w0", 64'(post_data), 64'h900);
        tick(); chk("t5_re_w1", 64'(post_data), 64'h905);
        tick(); chk("t5_re_done", 64'(done), 64'd1);
        tick();

        // reset mid-burst
        start_burst(52'h777, 52'h1, 16'd50);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_avail", 64'(post_avail), 64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_data",  64'(post_data),  64'd0);
        tick();

        // long burst with pseudo-random consumer stalls
        lfsr  = 4'b1001;
        k     = 0;
        dones = 0;
        tail  = -1;
        exp_w = 52'hA_BCDE_F012_3456;
        start_burst(52'hA_BCDE_F012_3456, 52'h123_4567, 16'd1000);
        for (int cyc = 0; cyc < 6000 && tail != 0; cyc++) begin
            if (done) begin
                dones++;
                if (tail < 0) tail = 5;
            end
            if (tail > 0) tail--;
            lfsr     = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            post_get = lfsr[0] | lfsr[2];
            if (post_avail && post_get) begin
                chk("t6_word", 64'(post_data), 64'(exp_w));
                exp_w = exp_w + 52'h123_4567;
                k++;
            end
            tick();
        end
        chk("t6_count", 64'(k),     64'd1000);
        chk("t6_dones", 64'(dones), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
